// File: rtl/cnt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cnt_sweep_ctrl
// Brief    : Drives the Up/Down command pins of a 4-bit up/down counter from
//            its live Count feedback. GOTO steps to a target; SWEEP runs a
//            triangle wave between Lo and Hi for a programmed period count.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Mode,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Target,
    input  logic [WIDTH-1:0] Lo,
    input  logic [WIDTH-1:0] Hi,
    input  logic [CYC_W-1:0] Cycles,
    input  logic [WIDTH-1:0] Count,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEEK     = 3'd1,
        S_SEEK_LO  = 3'd2,
        S_SWEEP_UP = 3'd3,
        S_SWEEP_DN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [CYC_W-1:0] C_ONE = CYC_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CYC_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             w_up, w_dn;

    // State and latched operands; Count itself is owned by the counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Next state and raw direction command; the command is chosen so that
    // the counter step and the state change land on the same edge.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        w_up    = 1'b0;
        w_dn    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    if (!Mode) begin
                        state_d = S_SEEK;
                        tgt_d   = Target;
                    end else if ((Lo < Hi) && (Cycles != '0)) begin
                        state_d = S_SEEK_LO;
                        lo_d    = Lo;
                        hi_d    = Hi;
                        rem_d   = Cycles;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_SEEK: begin
                if (Count < tgt_q) begin
                    w_up = 1'b1;
                end else if (Count > tgt_q) begin
                    w_dn = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SEEK_LO: begin
                if (Count < lo_q) begin
                    w_up = 1'b1;
                end else if (Count > lo_q) begin
                    w_dn = 1'b1;
                end else begin
                    // Lo < Hi is guaranteed, so the first upward step is safe.
                    w_up    = 1'b1;
                    state_d = S_SWEEP_UP;
                end
            end
            S_SWEEP_UP: begin
                if (Count < hi_q) begin
                    w_up = 1'b1;
                end else begin
                    w_dn    = 1'b1;
                    state_d = S_SWEEP_DN;
                end
            end
            S_SWEEP_DN: begin
                if (Count > lo_q) begin
                    w_dn = 1'b1;
                end else if (rem_q > C_ONE) begin
                    w_up    = 1'b1;
                    rem_d   = rem_q - C_ONE;
                    state_d = S_SWEEP_UP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over any progress outside IDLE.
        if (Abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Abort silences the counter in the same cycle it is raised.
    assign Up   = w_up & ~Abort;
    assign Down = w_dn & ~Abort;
    assign Busy = (state_q == S_SEEK)     || (state_q == S_SEEK_LO) ||
                  (state_q == S_SWEEP_UP) || (state_q == S_SWEEP_DN);
    assign Done = (state_q == S_DONE);
    assign Err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_sweep_ctrl
// Brief    : Self-checking bench for cnt_sweep_ctrl with a behavioural 4-bit
//            up/down counter closing the feedback loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_sweep_ctrl;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Mode;
    logic       Abort;
    logic [3:0] Target;
    logic [3:0] Lo;
    logic [3:0] Hi;
    logic [3:0] Cycles;
    logic [3:0] cnt;
    logic       Up;
    logic       Down;
    logic       Busy;
    logic       Done;
    logic       Err;

    logic       cnt_ld;
    logic [3:0] cnt_ld_val;

    int checks = 0;
    int errors = 0;
    int traj[$];

    cnt_sweep_ctrl #(.WIDTH(4), .CYC_W(4)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Mode   (Mode),
        .Abort  (Abort),
        .Target (Target),
        .Lo     (Lo),
        .Hi     (Hi),
        .Cycles (Cycles),
        .Count  (cnt),
        .Up     (Up),
        .Down   (Down),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural counter: not reset by the controller's reset.
    always @(posedge Clock) begin
        if (cnt_ld)             cnt <= cnt_ld_val;
        else if (Up && !Down)   cnt <= cnt + 4'd1;
        else if (Down && !Up)   cnt <= cnt - 4'd1;
    end

    typedef struct {
        bit mode;
        int c;
        int t;
        int lo;
        int hi;
        int cyc;
        bit exp_err;
        int exp_busy;
        int exp_final;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int c);
        cnt_ld     = 1'b1;
        cnt_ld_val = c[3:0];
        tick();
        cnt_ld     = 1'b0;
    endtask

    task automatic set_req(input bit m, input int t, input int lo, input int hi, input int cyc);
        Mode   = m;
        Target = t[3:0];
        Lo     = lo[3:0];
        Hi     = hi[3:0];
        Cycles = cyc[3:0];
    endtask

    // Appends a unit-step walk from a to b onto the expected trajectory.
    task automatic add_walk(input int a, input int b, input bit incl_a);
        int v;
        v = a;
        if (incl_a) traj.push_back(v);
        while (v != b) begin
            v += (b > v) ? 1 : -1;
            traj.push_back(v);
        end
    endtask

    // Reference: the Count value in every busy cycle, from the operation rules.
    task automatic build_traj(input bit m, input int c, input int t, input int lo, input int hi, input int cyc);
        traj.delete();
        if (!m) begin
            add_walk(c, t, 1'b1);
        end else begin
            add_walk(c, lo, 1'b1);
            for (int p = 0; p < cyc; p++) begin
                add_walk(lo, hi, 1'b0);
                add_walk(hi, lo, 1'b0);
            end
        end
    endtask

    // Table vector: count busy cycles, check Err/Done/final Count.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        load(v.c);
        set_req(v.mode, v.t, v.lo, v.hi, v.cyc);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        #1;
        chk($sformatf("vec%0d_err", idx), Err, v.exp_err);
        n = 0;
        while (Busy && n < 200) begin
            n++;
            tick();
            #1;
        end
        if (v.exp_err) begin
            chk($sformatf("vec%0d_err_busy", idx), n, 0);
            tick();
            #1;
            chk($sformatf("vec%0d_err_clear", idx), Err, 0);
        end else begin
            chk($sformatf("vec%0d_busy_len", idx), n, v.exp_busy);
            chk($sformatf("vec%0d_done", idx), Done, 1);
            chk($sformatf("vec%0d_final", idx), cnt, v.exp_final);
            tick();
            #1;
            chk($sformatf("vec%0d_done_clear", idx), Done, 0);
        end
    endtask

    // Random operation compared cycle by cycle against the trajectory model.
    task automatic run_model(input bit m, input int c, input int t, input int lo, input int hi, input int cyc);
        bit valid;
        int last;
        valid = !m || ((lo < hi) && (cyc != 0));
        load(c);
        build_traj(m, c, t, lo, hi, cyc);
        set_req(m, t, lo, hi, cyc);
        Start = 1'b1;
        #1;
        chk("rnd_idle_busy", Busy, 0);
        tick();
        Start = 1'b0;
        if (!valid) begin
            #1;
            chk("rnd_err", Err, 1);
            chk("rnd_err_busy", Busy, 0);
            tick();
            #1;
            chk("rnd_err_clear", Err, 0);
            return;
        end
        last = traj.size() - 1;
        for (int i = 0; i <= last; i++) begin
            // Stray requests while busy must not disturb the latched operands.
            Start = ($urandom_range(0, 3) == 0);
            set_req($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15));
            #1;
            chk("rnd_count", cnt, traj[i]);
            chk("rnd_up",   Up,   (i < last) && (traj[i+1] > traj[i]));
            chk("rnd_down", Down, (i < last) && (traj[i+1] < traj[i]));
            chk("rnd_busy", Busy, 1);
            chk("rnd_done_early", Done, 0);
            tick();
        end
        Start = 1'b0;
        #1;
        chk("rnd_done", Done, 1);
        chk("rnd_done_busy", Busy, 0);
        chk("rnd_done_cmd", {Up, Down}, 0);
        chk("rnd_final", cnt, traj[last]);
        tick();
        #1;
        chk("rnd_done_clear", Done, 0);
    endtask

    initial begin
        int c0;
        int lo;
        int hi;
        Start = 1'b0; Abort = 1'b0; cnt_ld = 1'b0; cnt_ld_val = 4'd0;
        set_req(1'b0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1 Reset = 1'b0;
        cnt_ld = 1'b1; cnt_ld_val = 4'd7;
        tick();
        tick();
        cnt_ld = 1'b0;
        chk("rst_outputs", {Up, Down, Busy, Done, Err}, 0);
        Reset = 1'b1;

        // Idle after reset: nothing moves.
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("idle_outputs", {Up, Down, Busy, Done, Err}, 0);
            chk("idle_count", cnt, 7);
        end

        vecs[0] = '{0,  3,  9, 0,  0, 0, 0,  7,  9};
        vecs[1] = '{0,  3,  1, 0,  0, 0, 0,  3,  1};
        vecs[2] = '{0,  5,  5, 0,  0, 0, 0,  1,  5};
        vecs[3] = '{0,  0, 15, 0,  0, 0, 0, 16, 15};
        vecs[4] = '{1,  0,  0, 2,  5, 2, 0, 15,  2};
        vecs[5] = '{1,  0,  0, 5,  5, 1, 1,  0,  0};
        vecs[6] = '{1,  0,  0, 1,  4, 0, 1,  0,  0};
        vecs[7] = '{1, 15,  0, 0, 15, 1, 0, 46,  0};
        vecs[8] = '{1,  7,  0, 3,  4, 3, 0, 11,  3};
        vecs[9] = '{1,  9,  0, 2,  5, 1, 0, 14,  2};
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Abort in SWEEP_UP at Count=4 with a simultaneous Start.
        load(0);
        set_req(1'b1, 0, 2, 5, 2);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Abort = 1'b1; Start = 1'b1; set_req(1'b0, 9, 0, 0, 0);
        #1;
        chk("abort_count", cnt, 4);
        chk("abort_cmd", {Up, Down}, 0);
        tick();
        Abort = 1'b0; Start = 1'b0;
        #1;
        chk("abort_idle", {Busy, Done, Up, Down}, 0);
        tick();
        #1;
        chk("abort_frozen", cnt, 4);
        chk("abort_no_done", {Busy, Done}, 0);

        // Start together with Abort in IDLE: no Err, no operation.
        set_req(1'b1, 0, 5, 5, 1);
        Start = 1'b1; Abort = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        #1;
        chk("start_abort_idle", {Err, Busy}, 0);

        // Abort during DONE still shows the Done pulse.
        load(6);
        set_req(1'b0, 6, 0, 0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        #1;
        chk("eq_seek_cmd", {Busy, Up, Down}, 3'b100);
        tick();
        Abort = 1'b1;
        #1;
        chk("abort_in_done", Done, 1);
        tick();
        Abort = 1'b0;
        #1;
        chk("after_done_abort", {Done, Busy}, 0);

        // Asynchronous reset mid-GOTO.
        load(3);
        set_req(1'b0, 9, 0, 0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        #1;
        chk("pre_rst_up", {Up, Busy}, 2'b11);
        Reset = 1'b0;
        #1;
        chk("async_rst_drop", {Up, Down, Busy}, 0);
        #3 Reset = 1'b1;
        tick();
        #1;
        chk("post_rst_idle", {Up, Down, Busy, Done}, 0);
        chk("post_rst_count", cnt, 5);

        // Randomized operations against the trajectory model.
        for (int k = 0; k < 40; k++) begin
            c0 = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                run_model(1'b0, c0, $urandom_range(0, 15), 0, 0, 0);
            end else begin
                if ($urandom_range(0, 3) != 0) begin
                    lo = $urandom_range(0, 14);
                    hi = $urandom_range(lo + 1, 15);
                end else begin
                    lo = $urandom_range(0, 15);
                    hi = $urandom_range(0, 15);
                end
                run_model(1'b1, c0, 0, lo, hi, $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
